// File: rtl/neuron_sweep_scheduler_if.sv
// Scheduler <-> layer datapath bundle: stimulus fetch, integrator strobe, spike event stream.
// Handshakes: stim_req is held until stim_valid answers; spk_valid/spk_addr are held until a cycle with spk_ready.
interface neuron_sweep_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 25
);
  logic              stim_req;
  logic [ADDR_W-1:0] stim_addr;
  logic              stim_valid;
  logic [WIDTH-1:0]  stim_data;
  logic              nrn_en;
  logic [WIDTH-1:0]  nrn_stim;
  logic              nrn_valid;
  logic              nrn_spike;
  logic              spk_valid;
  logic [ADDR_W-1:0] spk_addr;
  logic              spk_ready;

  modport master (
    output stim_req, stim_addr, nrn_en, nrn_stim, spk_valid, spk_addr,
    input  stim_valid, stim_data, nrn_valid, nrn_spike, spk_ready
  );

  modport slave (
    input  stim_req, stim_addr, nrn_en, nrn_stim, spk_valid, spk_addr,
    output stim_valid, stim_data, nrn_valid, nrn_spike, spk_ready
  );
endinterface

// File: rtl/neuron_sweep_scheduler.sv
// Per-timestep sweep of one integrate-and-fire layer: fetch, fire, wait, emit spike events.
// Optional SCHED_SPIKE_COUNT_EN adds a per-sweep spike_count output.
module neuron_sweep_scheduler #(
  parameter int N_NEURONS     = 256,
  parameter int WIDTH         = 25,
  parameter int ADDR_W        = $clog2(N_NEURONS),
  parameter int VALID_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [ADDR_W:0]     n_active,
  neuron_sweep_scheduler_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                timeout_err,
  output logic [2:0]          state_dbg
`ifdef SCHED_SPIKE_COUNT_EN
  ,
  output logic [ADDR_W:0]     spike_count
`endif
);

  localparam int TO_W = $clog2(VALID_TIMEOUT + 1);
  localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W+1)'(N_NEURONS);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(VALID_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FIRE   = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   clip;
  logic [TO_W-1:0]   wait_cnt;
  logic [WIDTH-1:0]  stim_q;
  logic              accept, capture, adv, to_hit, last;

  assign clip = (n_active > MAX_CNT) ? MAX_CNT : n_active;
  // Compare addr+1 against count so a count of 0 never needs a negative bound.
  assign last = (({1'b0, addr} + (ADDR_W+1)'(1)) == count);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    adv     = 1'b0;
    to_hit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          accept  = 1'b1;
          state_n = (clip == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.stim_valid) begin
          capture = 1'b1;
          state_n = S_FIRE;
        end
      end
      S_FIRE:  state_n = S_WAIT;
      S_WAIT: begin
        if (bus.nrn_valid) begin
          if (bus.nrn_spike) state_n = S_EMIT;
          else               adv     = 1'b1;
        end else if (wait_cnt == TO_LIMIT) begin
          to_hit = 1'b1;
          adv    = 1'b1;
        end
      end
      S_EMIT: begin
        if (bus.spk_ready) adv = 1'b1;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (adv) state_n = last ? S_FINISH : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      count       <= '0;
      wait_cnt    <= '0;
      stim_q      <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        count <= clip;
        addr  <= '0;
      end
      if (capture) stim_q <= bus.stim_data;
      if (state == S_FIRE)      wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + TO_W'(1);
      if (adv && !last) addr <= addr + ADDR_W'(1);
      if (to_hit) timeout_err <= 1'b1;
      if (tick && state != S_IDLE) overrun <= 1'b1;
    end
  end

`ifdef SCHED_SPIKE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                spike_count <= '0;
    else if (accept)                        spike_count <= '0;
    else if (bus.spk_valid && bus.spk_ready) spike_count <= spike_count + (ADDR_W+1)'(1);
  end
`endif

  assign bus.stim_req  = (state == S_FETCH);
  assign bus.stim_addr = addr;
  assign bus.nrn_en    = (state == S_FIRE);
  assign bus.nrn_stim  = stim_q;
  assign bus.spk_valid = (state == S_EMIT);
  assign bus.spk_addr  = addr;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_FINISH);
  assign state_dbg     = state;

endmodule

// File: tb/tb_neuron_sweep_scheduler.sv
// Directed bench for neuron_sweep_scheduler: layer/stimulus responder, monitor with address scoreboard.
module tb_neuron_sweep_scheduler;

  localparam int N  = 256;
  localparam int W  = 25;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [AW:0]   n_active;
  logic          busy, done, overrun, timeout_err;
  logic [2:0]    state_dbg;
`ifdef SCHED_SPIKE_COUNT_EN
  logic [AW:0]   spike_count;
`endif

  neuron_sweep_scheduler_if #(.ADDR_W(AW), .WIDTH(W)) bus ();

  neuron_sweep_scheduler #(.N_NEURONS(N), .WIDTH(W), .VALID_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .n_active    (n_active),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
`ifdef SCHED_SPIKE_COUNT_EN
    ,
    .spike_count (spike_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard and counters
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] spk_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int en_cnt, req_cycles, busy_cycles, spkv_cycles, done_cnt;
  int last_valid_cyc, done_cyc, en2_cyc, to_cyc;
  logic prev_spkv = 1'b0;
  logic prev_to   = 1'b0;
  logic [AW-1:0] prev_spk_addr = '0;

  // layer model controls
  logic [N-1:0] spike_mask;
  int supp_addr;
  int ready_delay;
  int cd = 0;
  int hold = 0;
  logic [AW-1:0] cur = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] stim_of(input logic [AW-1:0] a);
    return W'(32'(a) * 7 + 100);
  endfunction

  // responder: stimulus memory, integrator with 2-cycle valid latency, spike sink
  always begin
    @(negedge clk);
    bus.stim_valid = bus.stim_req;
    bus.stim_data  = stim_of(bus.stim_addr);
    bus.nrn_valid  = 1'b0;
    bus.nrn_spike  = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0 && 32'(cur) != supp_addr) begin
        bus.nrn_valid = 1'b1;
        bus.nrn_spike = spike_mask[cur];
      end
    end
    if (bus.nrn_en) begin
      cd  = 2;
      cur = bus.stim_addr;
    end
    if (bus.spk_valid) begin
      bus.spk_ready = (hold >= ready_delay);
      hold++;
    end else begin
      bus.spk_ready = 1'b0;
      hold = 0;
    end
  end

  // monitor: sampled 1 time unit after the falling edge
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (bus.nrn_en) begin
      en_cnt++;
      if (exp_q.size() == 0) check("en_unexpected", 32'(bus.stim_addr), 32'hFFFF_FFFF);
      else                   check("en_addr", 32'(bus.stim_addr), 32'(exp_q.pop_front()));
      check("nrn_stim", 32'(bus.nrn_stim), 32'(stim_of(bus.stim_addr)));
      if (bus.stim_addr == AW'(2)) en2_cyc = cyc;
    end
    if (bus.stim_req)  req_cycles++;
    if (busy)          busy_cycles++;
    if (bus.nrn_valid) last_valid_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.spk_valid) begin
      spkv_cycles++;
      if (prev_spkv) check("spk_addr_hold", 32'(bus.spk_addr), 32'(prev_spk_addr));
      if (bus.spk_ready) spk_q.push_back(bus.spk_addr);
    end
    prev_spkv     = bus.spk_valid;
    prev_spk_addr = bus.spk_addr;
    if (timeout_err && !prev_to) to_cyc = cyc;
    prev_to = timeout_err;
  end

  // driver tasks
  task automatic clear_stats();
    en_cnt = 0; req_cycles = 0; busy_cycles = 0; spkv_cycles = 0;
    last_valid_cyc = 0; done_cyc = 0; en2_cyc = 0; to_cyc = 0;
    spk_q.delete();
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(AW'(i));
  endtask

  task automatic do_tick(input int n);
    @(negedge clk);
    tick = 1'b1;
    n_active = (AW+1)'(n);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt != start) break;
    end
    check(tag, 32'(done_cnt != start), 32'd1);
  endtask

  task automatic run_sweep(input string tag, input int n, input int n_exp, input int budget);
    clear_stats();
    push_addrs(n_exp);
    do_tick(n);
    wait_done(tag, budget);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; n_active = '0;
    spike_mask = '0; supp_addr = -1; ready_delay = 0;
    bus.stim_valid = 1'b0; bus.stim_data = '0;
    bus.nrn_valid = 1'b0; bus.nrn_spike = 1'b0; bus.spk_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({overrun, timeout_err}), 32'd0);
    check("rst_outs", 32'({bus.stim_req, bus.nrn_en, bus.spk_valid}), 32'd0);
    check("rst_nrn_stim", 32'(bus.nrn_stim), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // four neurons, no spikes
    run_sweep("done_n4", 4, 4, 100);
    check("n4_en_cnt", 32'(en_cnt), 32'd4);
    check("n4_spkv", 32'(spkv_cycles), 32'd0);
    check("n4_done_lat", 32'(done_cyc - last_valid_cyc), 32'd1);
    check("n4_busy", 32'(busy_cycles), 32'd17);
    check("n4_sb_empty", 32'(exp_q.size()), 32'd0);

    // spike on address 1 with a slow sink
    spike_mask = '0; spike_mask[1] = 1'b1; ready_delay = 5;
    run_sweep("done_n3", 3, 3, 100);
    check("n3_en_cnt", 32'(en_cnt), 32'd3);
    check("n3_spkv", 32'(spkv_cycles), 32'd6);
    check("n3_evt_cnt", 32'(spk_q.size()), 32'd1);
    if (spk_q.size() > 0) check("n3_evt_addr", 32'(spk_q[0]), 32'd1);
    check("n3_busy", 32'(busy_cycles), 32'd19);
`ifdef SCHED_SPIKE_COUNT_EN
    check("n3_spike_count", 32'(spike_count), 32'd1);
`endif

    // empty sweep
    spike_mask = '0; ready_delay = 0;
    run_sweep("done_n0", 0, 0, 20);
    check("n0_busy", 32'(busy_cycles), 32'd1);
    check("n0_req", 32'(req_cycles), 32'd0);
    check("n0_en", 32'(en_cnt), 32'd0);

    // oversize request clipped to N
    spike_mask[0] = 1'b1; spike_mask[255] = 1'b1;
    run_sweep("done_n300", 300, 256, 3000);
    check("n300_en_cnt", 32'(en_cnt), 32'd256);
    check("n300_evt_cnt", 32'(spk_q.size()), 32'd2);
    if (spk_q.size() == 2) begin
      check("n300_evt0", 32'(spk_q[0]), 32'd0);
      check("n300_evt1", 32'(spk_q[1]), 32'd255);
    end
    check("n300_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef SCHED_SPIKE_COUNT_EN
    check("n300_spike_count", 32'(spike_count), 32'd2);
`endif
    check("no_overrun_yet", 32'(overrun), 32'd0);

    // tick while busy
    spike_mask = '0;
    clear_stats();
    push_addrs(4);
    do_tick(4);
    repeat (3) @(negedge clk);
    tick = 1'b1; n_active = (AW+1)'(1);
    @(negedge clk);
    tick = 1'b0;
    wait_done("done_ovr", 100);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_en_cnt", 32'(en_cnt), 32'd4);
    run_sweep("done_after_ovr", 2, 2, 100);
    check("after_ovr_en_cnt", 32'(en_cnt), 32'd2);
`ifdef SCHED_SPIKE_COUNT_EN
    check("after_ovr_spike_count", 32'(spike_count), 32'd0);
`endif

    // missing valid on address 2
    supp_addr = 2;
    run_sweep("done_to", 4, 4, 200);
    check("to_flag", 32'(timeout_err), 32'd1);
    check("to_lat", 32'(to_cyc - en2_cyc), 32'd16);
    check("to_en_cnt", 32'(en_cnt), 32'd4);
    check("to_busy", 32'(busy_cycles), 32'd30);
    supp_addr = -1;

    // reset while holding a spike event
    spike_mask = '0; spike_mask[0] = 1'b1; ready_delay = 100;
    clear_stats();
    push_addrs(3);
    do_tick(3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (bus.spk_valid) break;
    end
    check("emit_reached", 32'(bus.spk_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("emit_rst_state", 32'(state_dbg), 32'd0);
    check("emit_rst_spkv", 32'(bus.spk_valid), 32'd0);
    check("emit_rst_busy", 32'(busy), 32'd0);
    check("emit_rst_flags", 32'({overrun, timeout_err}), 32'd0);
    check("emit_rst_nrn_stim", 32'(bus.nrn_stim), 32'd0);
`ifdef SCHED_SPIKE_COUNT_EN
    check("emit_rst_spike_count", 32'(spike_count), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    spike_mask = '0; ready_delay = 0;
    run_sweep("done_post_rst", 2, 2, 100);
    check("post_rst_en_cnt", 32'(en_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
